register_bank_sb: RTL and testbench

Parametrised multi-port register file with write-to-read bypass, optional hard-wired zero register, and an integrated per-register pending-write scoreboard. It sits between decode/issue and writeback in the MIPS datapath. Issue reserves a destination register. Decode reads operands together with per-port ready flags. Writeback commits data and releases the reservation.

---
 rtl/register_bank_sb.sv | 96 +++++++++
 tb/tb_register_bank_sb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_sb.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_sb
// Description : Multi-port register file with write-to-read bypass, optional
//               hard-wired zero register and a per-register pending scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
    output logic [READ_PORTS-1:0]            read_ready,
    input  logic [ADDR_WIDTH-1:0]            write_address,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic                             write_enable,
    input  logic [ADDR_WIDTH-1:0]            reserve_address,
    input  logic                             reserve_enable,
    output logic [(2**ADDR_WIDTH)-1:0]       pending,
    output logic                             double_reserve
);

    localparam int c_num_regs = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_num_regs];
    logic [c_num_regs-1:0] r_pending;
    logic                  r_double_reserve;

    logic w_write_ok;
    logic w_reserve_ok;
    logic w_double_hit;

    // Requests aimed at a hard-wired zero register are dropped entirely.
    assign w_write_ok   = write_enable &&
                          !((ZERO_REG != 0) && (write_address == '0));
    assign w_reserve_ok = reserve_enable &&
                          !((ZERO_REG != 0) && (reserve_address == '0));
    assign w_double_hit = w_reserve_ok && r_pending[reserve_address] &&
                          !(w_write_ok && (write_address == reserve_address));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < c_num_regs; i++) begin
                r_mem[i] <= '0;
            end
            r_pending        <= '0;
            r_double_reserve <= 1'b0;
        end else begin
            if (w_write_ok) begin
                r_mem[write_address]     <= write_data;
                r_pending[write_address] <= 1'b0;
            end
            // Placed after the release so a same-cycle new producer wins.
            if (w_reserve_ok) begin
                r_pending[reserve_address] <= 1'b1;
            end
            if (w_double_hit) begin
                r_double_reserve <= 1'b1;
            end
        end
    end

    assign pending        = r_pending;
    assign double_reserve = r_double_reserve;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_ready;

        assign w_addr = read_address[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_data  = r_mem[w_addr];
            w_ready = ~r_pending[w_addr];
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_data  = '0;
                w_ready = 1'b1;
            end else if ((BYPASS != 0) && w_write_ok && (write_address == w_addr)) begin
                w_data  = write_data;
                w_ready = 1'b1;
            end
        end

        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign read_ready[p]                         = w_ready;
    end

endmodule
`default_nettype wire

// File: tb/tb_register_bank_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_bank_sb
// Description : Self-checking bench for register_bank_sb (bypass and
//               no-bypass builds driven in lockstep) against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 2;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [RP*AW-1:0] read_address;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          write_enable;
    logic [AW-1:0] reserve_address;
    logic          reserve_enable;

    logic [RP*DW-1:0] rd_b, rd_n;
    logic [RP-1:0]    rr_b, rr_n;
    logic [NR-1:0]    pend_b, pend_n;
    logic             dbl_b, dbl_n;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [DW-1:0] m_mem [NR];
    bit            m_pend [NR];
    bit            m_dbl;

    always #5 clk = ~clk;

    register_bank_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP),
                       .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .read_address(read_address),
        .read_data(rd_b), .read_ready(rr_b), .write_address(write_address),
        .write_data(write_data), .write_enable(write_enable),
        .reserve_address(reserve_address), .reserve_enable(reserve_enable),
        .pending(pend_b), .double_reserve(dbl_b));

    register_bank_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP),
                       .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .read_address(read_address),
        .read_data(rd_n), .read_ready(rr_n), .write_address(write_address),
        .write_data(write_data), .write_enable(write_enable),
        .reserve_address(reserve_address), .reserve_enable(reserve_enable),
        .pending(pend_n), .double_reserve(dbl_n));

    function automatic logic [DW-1:0] exp_data(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && write_enable && int'(write_address) == a) return write_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_ready(input int a, input bit byp);
        if (a == 0) return 1'b1;
        if (byp && write_enable && int'(write_address) == a) return 1'b1;
        return !m_pend[a];
    endfunction

    function automatic logic [NR-1:0] exp_pending();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < RP; p++) begin
            int a;
            a = int'(read_address[p*AW +: AW]);
            chk($sformatf("%s byp_data[%0d] a=%0d", tag, p, a), rd_b[p*DW +: DW], exp_data(a, 1'b1));
            chk($sformatf("%s byp_rdy[%0d] a=%0d", tag, p, a), {31'd0, rr_b[p]}, {31'd0, exp_ready(a, 1'b1)});
            chk($sformatf("%s nob_data[%0d] a=%0d", tag, p, a), rd_n[p*DW +: DW], exp_data(a, 1'b0));
            chk($sformatf("%s nob_rdy[%0d] a=%0d", tag, p, a), {31'd0, rr_n[p]}, {31'd0, exp_ready(a, 1'b0)});
        end
        chk({tag, " pending_b"}, pend_b, exp_pending());
        chk({tag, " pending_n"}, pend_n, exp_pending());
        chk({tag, " dbl_b"}, {31'd0, dbl_b}, {31'd0, m_dbl});
        chk({tag, " dbl_n"}, {31'd0, dbl_n}, {31'd0, m_dbl});
    endtask

    // Advance one edge and apply the architectural rules to the model.
    task automatic tick();
        bit wr, rs;
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 0;
            end
            m_dbl = 0;
        end else begin
            wr = write_enable && write_address != 0;
            rs = reserve_enable && reserve_address != 0;
            if (rs && m_pend[reserve_address] && !(wr && write_address == reserve_address))
                m_dbl = 1;
            if (wr) m_mem[write_address] = write_data;
            for (int i = 0; i < NR; i++) begin
                if (rs && int'(reserve_address) == i) m_pend[i] = 1;
                else if (wr && int'(write_address) == i) m_pend[i] = 0;
            end
        end
        #1;
    endtask

    task automatic drive(input bit rst_n, input bit we, input int wa, input logic [DW-1:0] wd,
                         input bit re, input int ra, input int a0, input int a1);
        reset_n         = rst_n;
        write_enable    = we;
        write_address   = AW'(wa);
        write_data      = wd;
        reserve_enable  = re;
        reserve_address = AW'(ra);
        read_address    = {AW'(a1), AW'(a0)};
        #2;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 0;
        end
        m_dbl = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        for (int a = 0; a < NR; a++) begin
            drive(1, 0, 0, 0, 0, 0, a, NR - 1 - a);
            check_all("post_reset");
        end

        drive(1, 1, 7, 32'hDEADBEEF, 0, 0, 7, 7);
        check_all("wr7_same");
        tick();
        drive(1, 0, 0, 0, 0, 0, 7, 7);
        check_all("rd7");
        drive(1, 1, 0, 32'h1234, 0, 0, 0, 0);
        check_all("wr0_same");
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 7);
        check_all("rd0");

        drive(1, 0, 0, 0, 1, 5, 5, 5);
        tick();
        drive(1, 0, 0, 0, 0, 0, 5, 5);
        check_all("r5_pending");
        drive(1, 1, 5, 32'h55, 0, 0, 5, 5);
        check_all("r5_bypass");
        tick();
        drive(1, 0, 0, 0, 0, 0, 5, 5);
        check_all("r5_released");

        drive(1, 1, 9, 32'hA5A5A5A5, 1, 9, 9, 9);
        tick();
        drive(1, 0, 0, 0, 0, 0, 9, 0);
        check_all("r9_wr_res");

        drive(1, 0, 0, 0, 1, 3, 3, 3);
        tick();
        drive(1, 0, 0, 0, 1, 3, 3, 3);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3, 3);
        check_all("r3_double");
        drive(1, 1, 3, 32'h1, 0, 0, 3, 9);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3, 9);
        check_all("r3_sticky");

        drive(0, 1, 4, 32'h77, 1, 2, 4, 2);
        check_all("rst_inflight");
        tick();
        drive(1, 0, 0, 0, 0, 0, 4, 2);
        check_all("after_rst");

        for (int n = 0; n < 400; n++) begin
            int wa, a0, a1;
            wa = int'($urandom_range(0, NR - 1));
            a0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NR - 1));
            a1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NR - 1));
            drive(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1, wa, $urandom,
                  $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), a0, a1);
            check_all("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
